// File: rtl/unit_dispatch_pkg.sv
// Shared constants for the dispatch / result-selection pair: unit select
// encodings, FSM state encoding and the select-to-unit one-hot decode.
package unit_dispatch_pkg;

    localparam logic [1:0] SEL_GREEN  = 2'b00;
    localparam logic [1:0] SEL_BLUE0  = 2'b01;
    localparam logic [1:0] SEL_BLUE1  = 2'b10;
    localparam logic [1:0] SEL_YELLOW = 2'b11;

    localparam int unsigned UNIT_N   = 3;
    localparam int unsigned UNIT_GRN = 0;
    localparam int unsigned UNIT_BLU = 1;
    localparam int unsigned UNIT_YEL = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    // One-hot unit vector {yellow, blue, green} for a given select code.
    function automatic logic [UNIT_N-1:0] sel_to_unit(input logic [1:0] sel);
        logic [UNIT_N-1:0] oh;
        oh = '0;
        case (sel)
            SEL_GREEN:  oh[UNIT_GRN] = 1'b1;
            SEL_BLUE0:  oh[UNIT_BLU] = 1'b1;
            SEL_BLUE1:  oh[UNIT_BLU] = 1'b1;
            SEL_YELLOW: oh[UNIT_YEL] = 1'b1;
            default:    oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/unit_dispatch_timer.sv
// dispatch_timer: clearable, incrementing wait counter for the ISSUE state.
// expire_o is high while the count sits at TIMEOUT-1.
module dispatch_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int unsigned T_W = $clog2(TIMEOUT + 1);

    logic [T_W-1:0] cnt_q;
    logic [T_W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + T_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == T_W'(TIMEOUT - 1));

endmodule

// File: rtl/unit_dispatch.sv
// unit_dispatch: accepts one instruction, holds it, and issues it to the
// green, blue or yellow execution unit chosen by opCode[15:14].
// Optional per-unit issue counters are built when DISPATCH_STATS_EN is defined;
// otherwise the count ports are tied to zero.
module unit_dispatch
    import unit_dispatch_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ZNC_W   = 3,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       opCode,
    input  logic [DATA_W-1:0] A_in,
    input  logic [DATA_W-1:0] B_in,
    input  logic [ZNC_W-1:0]  ZNC_in,
    output logic [15:0]       op_issue,
    output logic [DATA_W-1:0] A_issue,
    output logic [DATA_W-1:0] B_issue,
    output logic [ZNC_W-1:0]  ZNC_issue,
    output logic              green_valid,
    output logic              blue_valid,
    output logic              yellow_valid,
    input  logic              green_ready,
    input  logic              blue_ready,
    input  logic              yellow_ready,
    output logic              busy,
    output logic [1:0]        last_sel,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  green_cnt,
    output logic [CNT_W-1:0]  blue_cnt,
    output logic [CNT_W-1:0]  yellow_cnt
);

    state_e            state_q;
    logic [15:0]       op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [ZNC_W-1:0]  znc_q;
    logic [1:0]        sel_q;
    logic [1:0]        last_sel_q;
    logic              timeout_err_q;

    logic [UNIT_N-1:0] unit_oh;
    logic [UNIT_N-1:0] ready_vec;
    logic              busy_c;
    logic              hs_c;
    logic              accept_c;
    logic              expire_c;
    logic              drop_c;

    // Unit decode uses only the held select, never the live opCode.
    assign unit_oh   = sel_to_unit(sel_q);
    assign ready_vec = {yellow_ready, blue_ready, green_ready};
    assign busy_c    = (state_q == ST_ISSUE);
    assign hs_c      = busy_c & |(unit_oh & ready_vec);
    assign in_ready  = busy_c ? hs_c : 1'b1;
    assign accept_c  = in_valid & in_ready;
    assign drop_c    = busy_c & ~hs_c & expire_c;

    dispatch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (accept_c | drop_c),
        .inc_i    (busy_c & ~hs_c & ~expire_c),
        .expire_o (expire_c)
    );

    // Dispatch FSM plus holding registers and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            znc_q         <= '0;
            sel_q         <= '0;
            last_sel_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= drop_c;
            if (hs_c) begin
                last_sel_q <= sel_q;
            end
            if (accept_c) begin
                op_q  <= opCode;
                a_q   <= A_in;
                b_q   <= B_in;
                znc_q <= ZNC_in;
                sel_q <= opCode[15:14];
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if ((hs_c && !in_valid) || drop_c) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign op_issue     = op_q;
    assign A_issue      = a_q;
    assign B_issue      = b_q;
    assign ZNC_issue    = znc_q;
    assign green_valid  = busy_c & unit_oh[UNIT_GRN];
    assign blue_valid   = busy_c & unit_oh[UNIT_BLU];
    assign yellow_valid = busy_c & unit_oh[UNIT_YEL];
    assign busy         = busy_c;
    assign last_sel     = last_sel_q;
    assign timeout_err  = timeout_err_q;

`ifdef DISPATCH_STATS_EN
    logic [CNT_W-1:0] green_cnt_q;
    logic [CNT_W-1:0] blue_cnt_q;
    logic [CNT_W-1:0] yellow_cnt_q;

    // Per-unit completed-handshake counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            green_cnt_q  <= '0;
            blue_cnt_q   <= '0;
            yellow_cnt_q <= '0;
        end else if (hs_c) begin
            if (unit_oh[UNIT_GRN]) green_cnt_q  <= green_cnt_q  + CNT_W'(1);
            if (unit_oh[UNIT_BLU]) blue_cnt_q   <= blue_cnt_q   + CNT_W'(1);
            if (unit_oh[UNIT_YEL]) yellow_cnt_q <= yellow_cnt_q + CNT_W'(1);
        end
    end

    assign green_cnt  = green_cnt_q;
    assign blue_cnt   = blue_cnt_q;
    assign yellow_cnt = yellow_cnt_q;
`else
    assign green_cnt  = '0;
    assign blue_cnt   = '0;
    assign yellow_cnt = '0;
`endif

endmodule

// File: tb/tb_unit_dispatch.sv
// Directed self-checking bench for unit_dispatch (short TIMEOUT for speed).
module tb_unit_dispatch;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ZNC_W  = 3;
    localparam int unsigned TO     = 8;
    localparam int unsigned CNT_W  = 16;

`ifdef DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       opCode;
    logic [DATA_W-1:0] A_in, B_in;
    logic [ZNC_W-1:0]  ZNC_in;
    logic [15:0]       op_issue;
    logic [DATA_W-1:0] A_issue, B_issue;
    logic [ZNC_W-1:0]  ZNC_issue;
    logic              green_valid, blue_valid, yellow_valid;
    logic              green_ready, blue_ready, yellow_ready;
    logic              busy;
    logic [1:0]        last_sel;
    logic              timeout_err;
    logic [CNT_W-1:0]  green_cnt, blue_cnt, yellow_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    unit_dispatch #(
        .DATA_W (DATA_W), .ZNC_W (ZNC_W), .TIMEOUT (TO), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .reset (reset),
        .in_valid (in_valid), .in_ready (in_ready),
        .opCode (opCode), .A_in (A_in), .B_in (B_in), .ZNC_in (ZNC_in),
        .op_issue (op_issue), .A_issue (A_issue), .B_issue (B_issue), .ZNC_issue (ZNC_issue),
        .green_valid (green_valid), .blue_valid (blue_valid), .yellow_valid (yellow_valid),
        .green_ready (green_ready), .blue_ready (blue_ready), .yellow_ready (yellow_ready),
        .busy (busy), .last_sel (last_sel), .timeout_err (timeout_err),
        .green_cnt (green_cnt), .blue_cnt (blue_cnt), .yellow_cnt (yellow_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected counter value depends on the build.
    function automatic logic [31:0] cexp(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; opCode = '0; A_in = '0; B_in = '0; ZNC_in = '0;
        green_ready = 1'b0; blue_ready = 1'b0; yellow_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valids", 32'({yellow_valid, blue_valid, green_valid}), 32'd0);
        chk("rst_last_sel", 32'(last_sel), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_op", 32'(op_issue), 32'd0);
        chk("rst_cnt", 32'(green_cnt) + 32'(blue_cnt) + 32'(yellow_cnt), 32'd0);

        // Green issue, single cycle latency
        in_valid = 1'b1; opCode = 16'h0012; A_in = 16'd5; B_in = 16'd7; ZNC_in = 3'b001;
        tick();
        in_valid = 1'b0; opCode = 16'hFFFF; A_in = 16'hAAAA;
        #1;
        chk("g_valids", 32'({yellow_valid, blue_valid, green_valid}), 32'b001);
        chk("g_A", 32'(A_issue), 32'd5);
        chk("g_B", 32'(B_issue), 32'd7);
        chk("g_ZNC", 32'(ZNC_issue), 32'd1);
        chk("g_op", 32'(op_issue), 32'h0012);
        chk("g_busy", 32'(busy), 32'd1);
        chk("g_in_ready_wait", 32'(in_ready), 32'd0);
        green_ready = 1'b1;
        #1;
        chk("g_in_ready_hs", 32'(in_ready), 32'd1);
        tick();
        green_ready = 1'b0;
        #1;
        chk("g_idle", 32'(busy), 32'd0);
        chk("g_valid_off", 32'(green_valid), 32'd0);
        chk("g_last_sel", 32'(last_sel), 32'd0);

        // Back-to-back blue issues via sel 01 then 10
        in_valid = 1'b1; opCode = 16'h4000; A_in = 16'd1;
        tick();
        blue_ready = 1'b1; opCode = 16'h8000; A_in = 16'd2;
        #1;
        chk("b1_valid", 32'({yellow_valid, blue_valid, green_valid}), 32'b010);
        chk("b1_A", 32'(A_issue), 32'd1);
        chk("b1_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("b2_valid", 32'({yellow_valid, blue_valid, green_valid}), 32'b010);
        chk("b2_op", 32'(op_issue), 32'h8000);
        chk("b2_A", 32'(A_issue), 32'd2);
        chk("b2_last_sel", 32'(last_sel), 32'd1);
        chk("b2_in_ready", 32'(in_ready), 32'd1);
        tick();
        blue_ready = 1'b0;
        #1;
        chk("b_idle", 32'(busy), 32'd0);
        chk("b_last_sel", 32'(last_sel), 32'd2);
        chk("b_cnt", 32'(blue_cnt), cexp(2));

        // Yellow timeout; other units ready but must be ignored
        green_ready = 1'b1; blue_ready = 1'b1;
        in_valid = 1'b1; opCode = 16'hC0FF;
        tick();
        in_valid = 1'b0;
        #1;
        chk("y_valids", 32'({yellow_valid, blue_valid, green_valid}), 32'b100);
        chk("y_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        chk("y_busy_last", 32'(busy), 32'd1);
        chk("y_terr_early", 32'(timeout_err), 32'd0);
        chk("y_in_ready_drop", 32'(in_ready), 32'd0);
        tick();
        chk("y_terr", 32'(timeout_err), 32'd1);
        chk("y_idle", 32'(busy), 32'd0);
        chk("y_last_sel", 32'(last_sel), 32'd2);
        chk("y_cnt", 32'(yellow_cnt), 32'd0);
        tick();
        chk("y_terr_pulse", 32'(timeout_err), 32'd0);
        green_ready = 1'b0; blue_ready = 1'b0;

        // Yellow handshake exactly on expiry cycle
        in_valid = 1'b1; opCode = 16'hC001;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        yellow_ready = 1'b1;
        #1;
        chk("ye_in_ready", 32'(in_ready), 32'd1);
        tick();
        yellow_ready = 1'b0;
        #1;
        chk("ye_terr", 32'(timeout_err), 32'd0);
        chk("ye_idle", 32'(busy), 32'd0);
        chk("ye_last_sel", 32'(last_sel), 32'd3);
        chk("ye_cnt", 32'(yellow_cnt), cexp(1));
        tick();
        chk("ye_terr2", 32'(timeout_err), 32'd0);

        // Reset while a blue entry is held
        in_valid = 1'b1; opCode = 16'h4123;
        tick();
        in_valid = 1'b0;
        #1;
        chk("r_blue_held", 32'(blue_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("r_blue_off", 32'(blue_valid), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_terr", 32'(timeout_err), 32'd0);
        chk("r_last_sel", 32'(last_sel), 32'd0);
        chk("r_cnt", 32'(blue_cnt), 32'd0);
        in_valid = 1'b1; opCode = 16'h0000; A_in = 16'd9;
        tick();
        in_valid = 1'b0;
        #1;
        chk("r_green_valid", 32'({yellow_valid, blue_valid, green_valid}), 32'b001);
        chk("r_green_A", 32'(A_issue), 32'd9);
        green_ready = 1'b1;
        tick();
        green_ready = 1'b0;
        #1;
        chk("r_green_done", 32'(busy), 32'd0);
        chk("r_green_cnt", 32'(green_cnt), cexp(1));

        // Ten issues across all units
        green_ready = 1'b1; blue_ready = 1'b1; yellow_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            opCode = {2'(i % 4), 14'(i)};
            tick();
            in_valid = 1'b0;
            tick();
        end
        green_ready = 1'b0; blue_ready = 1'b0; yellow_ready = 1'b0;
        #1;
        chk("t_idle", 32'(busy), 32'd0);
        chk("t_last_sel", 32'(last_sel), 32'd1);
        chk("t_green_cnt", 32'(green_cnt), cexp(4));
        chk("t_blue_cnt", 32'(blue_cnt), cexp(5));
        chk("t_yellow_cnt", 32'(yellow_cnt), cexp(2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
